cpu_trace_recorder: RTL and testbench

CPU_TRACE_RECORDER -- requirements
Module: cpu_trace_recorder

---
 rtl/cpu_trace_recorder.sv | 152 +++++++++++++++
 tb/tb_cpu_trace_recorder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_recorder.sv
// Instruction trace recorder: captures retiring instructions into a FWFT buffer
// under an IDLE/RECORD/HALTED control FSM, with cycle and retire counters.
module cpu_trace_recorder #(
    parameter int          DEPTH   = 16,
    parameter int          DATA_W  = 32,
    parameter int          CNT_W   = 32,
    parameter logic [5:0]  HALT_OP = 6'b111111,
    localparam int         LW      = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              stop,
    input  logic              wrap,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] ins_in,
    input  logic              pc_wre,
    input  logic              reg_wre,
    input  logic [4:0]        write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_ins,
    output logic [DATA_W-1:0] rd_wdata,
    output logic [4:0]        rd_wreg,
    output logic              rd_wflag,
    output logic [1:0]        state,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RECORD = 2'b01,
        HALTED = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      wrPtr_q, wrPtr_d;
    logic [AW-1:0]      rdPtr_q, rdPtr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cycleCnt_q, cycleCnt_d;
    logic [CNT_W-1:0]   retireCnt_q, retireCnt_d;

    logic [DATA_W-1:0]  pcMem    [DEPTH];
    logic [DATA_W-1:0]  insMem   [DEPTH];
    logic [DATA_W-1:0]  wdataMem [DEPTH];
    logic [4:0]         wregMem  [DEPTH];
    logic               wflagMem [DEPTH];

    logic clear, capture, pop, full, isHalt, memWrite;

    assign clear    = (state_q == IDLE) && arm && !stop;
    assign capture  = (state_q == RECORD) && pc_wre;
    assign pop      = rd_en && (level_q != '0) && !clear;
    assign full     = (level_q == LW'(DEPTH));
    assign isHalt   = (ins_in[31:26] == HALT_OP);
    // A full buffer accepts a new entry if a pop frees a slot or overwrite is enabled.
    assign memWrite = capture && (!full || pop || wrap);

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        cycleCnt_d  = cycleCnt_q;
        retireCnt_d = retireCnt_q;

        case (state_q)
            IDLE:    if (clear) state_d = RECORD;
            RECORD:  if (stop) state_d = IDLE;
                     else if (capture && isHalt) state_d = HALTED;
            HALTED:  if (stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            cycleCnt_d  = '0;
            retireCnt_d = '0;
        end else begin
            if (state_q == RECORD) begin
                if (cycleCnt_q != '1) cycleCnt_d = cycleCnt_q + CNT_W'(1);
                if (pc_wre && (retireCnt_q != '1)) retireCnt_d = retireCnt_q + CNT_W'(1);
            end
            if (memWrite) wrPtr_d = wrPtr_q + AW'(1);
            if (pop) rdPtr_d = rdPtr_q + AW'(1);
            if (memWrite && !pop) begin
                // Overwriting while full drops the oldest entry instead of growing.
                if (full) rdPtr_d = rdPtr_q + AW'(1);
                else      level_d = level_q + LW'(1);
            end else if (pop && !memWrite) begin
                level_d = level_q - LW'(1);
            end
            if (capture && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            cycleCnt_q  <= '0;
            retireCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            cycleCnt_q  <= cycleCnt_d;
            retireCnt_q <= retireCnt_d;
        end
    end

    // Storage needs no reset: readout is masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (memWrite) begin
            pcMem[wrPtr_q]    <= pc_in;
            insMem[wrPtr_q]   <= ins_in;
            wdataMem[wrPtr_q] <= write_data;
            wregMem[wrPtr_q]  <= write_reg;
            wflagMem[wrPtr_q] <= reg_wre;
        end
    end

    assign rd_valid   = (level_q != '0);
    assign rd_pc      = rd_valid ? pcMem[rdPtr_q]    : '0;
    assign rd_ins     = rd_valid ? insMem[rdPtr_q]   : '0;
    assign rd_wdata   = rd_valid ? wdataMem[rdPtr_q] : '0;
    assign rd_wreg    = rd_valid ? wregMem[rdPtr_q]  : '0;
    assign rd_wflag   = rd_valid & wflagMem[rdPtr_q];
    assign state      = state_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign cycle_cnt  = cycleCnt_q;
    assign retire_cnt = retireCnt_q;

endmodule

// File: tb/tb_cpu_trace_recorder.sv
// Randomised and directed bench for cpu_trace_recorder against a queue-based
// behavioural model of the trace buffer and control states.
module tb_cpu_trace_recorder;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;
    localparam int LW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              arm, stop, wrap, pc_wre, reg_wre, rd_en;
    logic [DATA_W-1:0] pc_in, ins_in, write_data;
    logic [4:0]        write_reg;
    logic              rd_valid, rd_wflag, overflow;
    logic [DATA_W-1:0] rd_pc, rd_ins, rd_wdata;
    logic [4:0]        rd_wreg;
    logic [1:0]        state;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  cycle_cnt, retire_cnt;

    cpu_trace_recorder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W), .HALT_OP(6'b111111)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .wrap(wrap),
        .pc_in(pc_in), .ins_in(ins_in), .pc_wre(pc_wre), .reg_wre(reg_wre),
        .write_reg(write_reg), .write_data(write_data), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ins(rd_ins), .rd_wdata(rd_wdata),
        .rd_wreg(rd_wreg), .rd_wflag(rd_wflag), .state(state), .level(level),
        .overflow(overflow), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        wf;
    } entry_t;

    entry_t      mq[$];
    int          mState;
    logic        mOvf;
    logic [31:0] mCyc, mRet;
    int          checks = 0;
    int          passes = 0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        else passes++;
    endtask

    task automatic resetModel();
        mq.delete();
        mState = 0;
        mOvf   = 1'b0;
        mCyc   = '0;
        mRet   = '0;
    endtask

    // One clock of recorder behaviour: reads come out before the new capture lands.
    task automatic modelStep(input logic a, input logic s, input logic w, input logic pw,
                             input entry_t e, input logic re);
        int nxt;
        nxt = mState;
        if (mState == 0 && a && !s) begin
            mq.delete();
            mOvf = 1'b0;
            mCyc = '0;
            mRet = '0;
            nxt  = 1;
        end else begin
            if (re && mq.size() > 0) void'(mq.pop_front());
            if (mState == 1) begin
                if (mCyc != 32'hFFFF_FFFF) mCyc = mCyc + 1;
                if (pw) begin
                    if (mRet != 32'hFFFF_FFFF) mRet = mRet + 1;
                    if (mq.size() < DEPTH) mq.push_back(e);
                    else begin
                        mOvf = 1'b1;
                        if (w) begin
                            void'(mq.pop_front());
                            mq.push_back(e);
                        end
                    end
                    if (e.ins[31:26] == 6'h3F) nxt = 2;
                end
            end
            if (s && mState != 0) nxt = 0;
        end
        mState = nxt;
    endtask

    task automatic checkAll(input string ctx);
        entry_t h;
        h = '{pc: '0, ins: '0, wd: '0, wr: '0, wf: 1'b0};
        if (mq.size() > 0) h = mq[0];
        checkOutput({ctx, ".state"},  64'(state),      64'(mState));
        checkOutput({ctx, ".level"},  64'(level),      64'(mq.size()));
        checkOutput({ctx, ".valid"},  64'(rd_valid),   64'(mq.size() > 0));
        checkOutput({ctx, ".ovf"},    64'(overflow),   64'(mOvf));
        checkOutput({ctx, ".cycle"},  64'(cycle_cnt),  64'(mCyc));
        checkOutput({ctx, ".retire"}, 64'(retire_cnt), 64'(mRet));
        checkOutput({ctx, ".rdpc"},   64'(rd_pc),      64'(h.pc));
        checkOutput({ctx, ".rdins"},  64'(rd_ins),     64'(h.ins));
        checkOutput({ctx, ".rdwd"},   64'(rd_wdata),   64'(h.wd));
        checkOutput({ctx, ".rdwr"},   64'(rd_wreg),    64'(h.wr));
        checkOutput({ctx, ".rdwf"},   64'(rd_wflag),   64'(h.wf));
    endtask

    // Drives one cycle of inputs, advances the model, then checks just after the edge.
    task automatic applyStimulus(input logic a, input logic s, input logic w, input logic pw,
                                 input logic [31:0] pc, input logic [31:0] ins, input logic re);
        entry_t e;
        e.pc = pc;
        e.ins = ins;
        e.wd = $urandom;
        e.wr = 5'($urandom_range(0, 31));
        e.wf = 1'($urandom_range(0, 1));
        arm = a; stop = s; wrap = w; pc_wre = pw; rd_en = re;
        pc_in = e.pc; ins_in = e.ins; write_data = e.wd; write_reg = e.wr; reg_wre = e.wf;
        modelStep(a, s, w, pw, e, re);
        @(posedge clk);
        #1;
        checkAll("cyc");
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    task automatic asyncReset();
        reset = 1'b0;
        #2;
        resetModel();
        checkAll("rstnow");
        @(posedge clk);
        #1;
        checkAll("rsthold");
        reset = 1'b1;
    endtask

    initial begin
        arm = 0; stop = 0; wrap = 0; pc_wre = 0; rd_en = 0; reg_wre = 0;
        pc_in = '0; ins_in = '0; write_data = '0; write_reg = '0;
        reset = 1'b0;
        resetModel();

        // Held reset: everything reads zero across clock edges.
        for (int i = 0; i < 10; i++) begin
            #10;
            checkAll("inreset");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idleCycles(2);

        // Five plain retires then drain in order.
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 32'(i * 4), 32'h0, 0);
        checkOutput("basic.level", 64'(level), 64'd5);
        checkOutput("basic.retire", 64'(retire_cnt), 64'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("basic.poppc", 64'(rd_pc), 64'(i * 4));
            applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        end
        checkOutput("basic.empty", 64'(rd_valid), 64'd0);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 0);

        // Circular overwrite keeps the newest sixteen.
        applyStimulus(1, 0, 1, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 1, 32'(i * 4), 32'h0, 0);
        checkOutput("wrap.level", 64'(level), 64'd16);
        checkOutput("wrap.ovf", 64'(overflow), 64'd1);
        checkOutput("wrap.firstpc", 64'(rd_pc), 64'h10);
        applyStimulus(0, 1, 1, 0, 32'h0, 32'h0, 0);

        // Frozen capture keeps the oldest sixteen but still counts retires.
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 32'(i * 4), 32'h0, 0);
        checkOutput("freeze.level", 64'(level), 64'd16);
        checkOutput("freeze.ovf", 64'(overflow), 64'd1);
        checkOutput("freeze.firstpc", 64'(rd_pc), 64'h0);
        checkOutput("freeze.retire", 64'(retire_cnt), 64'd20);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 0);

        // Halt opcode ends recording; later retires and arm are ignored.
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h18, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h1C, 32'h0, 0);
        applyStimulus(0, 0, 0, 1, 32'h20, 32'hFC00_0000, 0);
        checkOutput("halt.state", 64'(state), 64'h2);
        applyStimulus(0, 0, 0, 1, 32'h24, 32'h0, 0);
        applyStimulus(1, 0, 0, 1, 32'h28, 32'h0, 0);
        checkOutput("halt.level", 64'(level), 64'd3);
        checkOutput("halt.armign", 64'(state), 64'h2);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 1);
        checkOutput("halt.lastins", 64'(rd_ins), 64'hFC00_0000);
        checkOutput("halt.lastpc", 64'(rd_pc), 64'h20);
        applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 0);
        checkOutput("halt.stop", 64'(state), 64'h0);

        // Reset mid-recording discards everything; no capture without a new arm.
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 32'(i * 4), 32'h0, 0);
        asyncReset();
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 32'(32'h100 + i * 4), 32'h0, 0);
        checkOutput("rst.level", 64'(level), 64'd0);
        checkOutput("rst.state", 64'(state), 64'h0);

        // Random traffic in segments with varying wrap mode and read pressure.
        for (int seg = 0; seg < 8; seg++) begin
            logic w;
            int   popOdds;
            w = 1'($urandom_range(0, 1));
            popOdds = $urandom_range(1, 4);
            for (int i = 0; i < 200; i++) begin
                logic [31:0] ins;
                ins = $urandom;
                if ($urandom_range(0, 29) == 0) ins[31:26] = 6'h3F;
                else if (ins[31:26] == 6'h3F) ins[26] = 1'b0;
                applyStimulus(1'($urandom_range(0, 9) == 0),
                              1'($urandom_range(0, 39) == 0),
                              w,
                              1'($urandom_range(0, 1)),
                              $urandom, ins,
                              1'($urandom_range(0, popOdds) == 0));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
